countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_pkg.sv | 8 +
 rtl/countdown_timer_if.sv | 25 ++
 rtl/dec_chain.sv | 21 ++
 rtl/countdown_timer.sv | 59 +++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state type and default width.
package countdown_pkg;
   localparam int unsigned WIDTH_DEFAULT = 6;

   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t RUN  = 1'b1;
endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a timer client (master) and the countdown timer (slave).
interface countdown_timer_if
   import countdown_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) ();
   logic             start;
   logic [WIDTH-1:0] load_val;
   logic             reload_en;
   logic             halt;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   modport master (
      output start, load_val, reload_en, halt, abort,
      input  count, busy, done
   );

   modport slave (
      input  start, load_val, reload_en, halt, abort,
      output count, busy, done
   );
endinterface

// File: rtl/dec_chain.sv
// Combinational borrow-chain decrement (value - 1, modulo 2^WIDTH) with zero detect.
module dec_chain #(
   parameter int unsigned WIDTH = 6
) (
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] decr,
   output logic             zero
);
   logic borrow;

   always_comb begin
      decr   = '0;
      borrow = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         decr[i] = value[i] ^ borrow;
         borrow  = borrow & ~value[i];
      end
   end

   assign zero = ~|value;
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes, halt and abort.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input logic               clock,
   input logic               reset,
   countdown_timer_if.slave  bus
);
   state_t           state;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] reload_q;
   logic             done_q;
   logic [WIDTH-1:0] count_dec;
   logic             count_zero;

   dec_chain #(.WIDTH(WIDTH)) u_dec (
      .value (count_q),
      .decr  (count_dec),
      .zero  (count_zero)
   );

   // Abort wins over everything; halt also masks the terminal-count check.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.abort) begin
            state <= IDLE;
         end else if (state == IDLE) begin
            if (bus.start) begin
               count_q  <= bus.load_val;
               reload_q <= bus.load_val;
               state    <= RUN;
            end
         end else if (!bus.halt) begin
            if (count_zero) begin
               done_q <= 1'b1;
               if (bus.reload_en) begin
                  count_q <= reload_q;
               end else begin
                  state <= IDLE;
               end
            end else begin
               count_q <= count_dec;
            end
         end
      end
   end

   assign bus.count = count_q;
   assign bus.busy  = (state == RUN);
   assign bus.done  = done_q;
endmodule
